// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Produces per-domain active-low resets from the board reset, a PLL lock
// indication and a software reset request. All domain resets are asserted
// together on one edge. They are then released one stage at a time, lowest
// index first, so downstream domains leave reset in a fixed order.
//
// Parameters
//   STAGES        number of reset domains (>= 2)
//   HOLD_CYCLES   cycles all resets stay asserted after rst_n_i release (>= 1)
//   GAP_CYCLES    cycles between successive stage releases (>= 1)
//   SW_RST_CYCLES length of a software-requested reset (>= 1)
//
// Ports
//   clk_i           single clock
//   rst_n_i         asynchronous active-low board reset
//   lock_i          asynchronous PLL lock, double-flop synchronized internally
//   sw_rst_req_i    single-cycle synchronous software reset request
//   rst_n_o         per-domain active-low resets, bit 0 released first
//   ready_o         high only in RUN, once every stage is released
//   lock_loss_cnt_o saturating count of lock losses seen in RELEASE/RUN/SW_RST
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int STAGES        = 3,
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 4,
    parameter int SW_RST_CYCLES = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              lock_i,
    input  logic              sw_rst_req_i,
    output logic [STAGES-1:0] rst_n_o,
    output logic              ready_o,
    output logic [7:0]        lock_loss_cnt_o
);

    // One shared counter serves every timed state. Its largest terminal value
    // is (longest interval - 1), so $clog2 of the longest interval is enough.
    localparam int REL_CYCLES = STAGES * GAP_CYCLES;
    localparam int MAX_A      = (HOLD_CYCLES > REL_CYCLES) ? HOLD_CYCLES : REL_CYCLES;
    localparam int MAX_CYC    = (MAX_A > SW_RST_CYCLES) ? MAX_A : SW_RST_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REL_LAST    = CNT_W'(REL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [STAGES-1:0] FIRST_STAGE = STAGES'(1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_SW_RST
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [STAGES-1:0]  r_rst_n;
    logic [STAGES-1:0]  w_rst_n_next;
    logic               r_ready;
    logic               w_ready_next;
    logic [7:0]         r_loss_cnt;
    logic [7:0]         w_loss_cnt_next;
    logic               r_lock_meta;
    logic               r_lock_s;
    logic               w_lock_lost;
    logic [STAGES-1:0]  w_stage_hit;

    // w_stage_hit[k] marks the RELEASE count on whose edge stage k comes out of
    // reset. Stage 0 is released on RELEASE entry, so it never needs a hit.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage_hit
            if (gi == 0) begin : g_first
                assign w_stage_hit[gi] = 1'b0;
            end else begin : g_later
                assign w_stage_hit[gi] = (r_cnt == CNT_W'(gi * GAP_CYCLES - 1));
            end
        end
    endgenerate

    // Lock loss only matters once some stage may have been released, or while
    // a software reset is timing out. HOLD and WAIT_LOCK ignore it.
    assign w_lock_lost = !r_lock_s &&
                         ((r_state == S_RELEASE) || (r_state == S_RUN) || (r_state == S_SW_RST));

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_rst_n_next    = r_rst_n;
        w_loss_cnt_next = r_loss_cnt;

        if (w_lock_lost) begin
            // Highest priority: this wins over a coincident software request.
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
            w_rst_n_next = '0;
            if (r_loss_cnt != 8'hFF) begin
                w_loss_cnt_next = r_loss_cnt + 8'd1;
            end
        end else begin
            unique case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_next = S_WAIT_LOCK;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_next = S_RELEASE;
                        w_cnt_next   = '0;
                        w_rst_n_next = FIRST_STAGE;
                    end
                end
                S_RELEASE: begin
                    if (sw_rst_req_i) begin
                        w_state_next = S_SW_RST;
                        w_cnt_next   = '0;
                        w_rst_n_next = '0;
                    end else if (r_cnt == REL_LAST) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = '0;
                        w_rst_n_next = '1;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                        w_rst_n_next = r_rst_n | w_stage_hit;
                    end
                end
                S_RUN: begin
                    if (sw_rst_req_i) begin
                        w_state_next = S_SW_RST;
                        w_cnt_next   = '0;
                        w_rst_n_next = '0;
                    end
                end
                S_SW_RST: begin
                    // Repeated requests here are deliberately not looked at.
                    if (r_cnt == SW_LAST) begin
                        w_state_next = S_WAIT_LOCK;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = '0;
                    w_rst_n_next = '0;
                end
            endcase
        end

        w_ready_next = (w_state_next == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_rst_n     <= '0;
            r_ready     <= 1'b0;
            r_loss_cnt  <= 8'd0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rst_n     <= w_rst_n_next;
            r_ready     <= w_ready_next;
            r_loss_cnt  <= w_loss_cnt_next;
            r_lock_meta <= lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign rst_n_o         = r_rst_n;
    assign ready_o         = r_ready;
    assign lock_loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with default parameters. Each test
// task pushes the expected (edge, rst_n_o, ready_o, lock_loss_cnt_o) tuples
// into a queue as it drives stimulus, then pops and compares them when the
// counted edge arrives. Edges are numbered from 1 after the stimulus change.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk_i;
    logic       rst_n_i;
    logic       lock_i;
    logic       sw_rst_req_i;
    logic [2:0] rst_n_o;
    logic       ready_o;
    logic [7:0] lock_loss_cnt_o;

    reset_sequencer #(
        .STAGES        (3),
        .HOLD_CYCLES   (16),
        .GAP_CYCLES    (4),
        .SW_RST_CYCLES (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .lock_i          (lock_i),
        .sw_rst_req_i    (sw_rst_req_i),
        .rst_n_o         (rst_n_o),
        .ready_o         (ready_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int         at;
        logic [2:0] rst;
        logic       rdy;
        logic [7:0] loss;
    } exp_t;

    exp_t exp_q[$];
    exp_t ex;
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int at, input logic [2:0] r, input logic rd, input logic [7:0] l);
        exp_t t;
        t.at   = at;
        t.rst  = r;
        t.rdy  = rd;
        t.loss = l;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        rst_n_i      = 1'b0;
        lock_i       = 1'b1;
        sw_rst_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (rst_n_o !== 3'b000 || ready_o !== 1'b0 || lock_loss_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset: got rst=%b rdy=%b loss=%0d, want rst=000 rdy=0 loss=0",
                     rst_n_o, ready_o, lock_loss_cnt_o);
        end else begin
            $display("ok   reset: rst=%b rdy=%b loss=%0d", rst_n_o, ready_o, lock_loss_cnt_o);
        end
    endtask

    task automatic test_cold_start();
        push(1,  3'b000, 1'b0, 8'd0);
        push(16, 3'b000, 1'b0, 8'd0);
        push(17, 3'b001, 1'b0, 8'd0);
        push(20, 3'b001, 1'b0, 8'd0);
        push(21, 3'b011, 1'b0, 8'd0);
        push(24, 3'b011, 1'b0, 8'd0);
        push(25, 3'b111, 1'b0, 8'd0);
        push(28, 3'b111, 1'b0, 8'd0);
        push(29, 3'b111, 1'b1, 8'd0);
        push(31, 3'b111, 1'b1, 8'd0);
        rst_n_i = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL cold_start E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   cold_start E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
        end
    endtask

    task automatic test_late_lock();
        rst_n_i = 1'b0;
        lock_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        push(16, 3'b000, 1'b0, 8'd0);
        push(17, 3'b000, 1'b0, 8'd0);
        push(40, 3'b000, 1'b0, 8'd0);
        push(42, 3'b000, 1'b0, 8'd0);
        push(43, 3'b001, 1'b0, 8'd0);
        push(46, 3'b001, 1'b0, 8'd0);
        push(47, 3'b011, 1'b0, 8'd0);
        push(51, 3'b111, 1'b0, 8'd0);
        push(54, 3'b111, 1'b0, 8'd0);
        push(55, 3'b111, 1'b1, 8'd0);
        rst_n_i = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL late_lock E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   late_lock E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
            if (e == 40) lock_i = 1'b1;
        end
    endtask

    // Request at edge 1; a second request at edge 3 lands inside SW_RST and
    // must not stretch it.
    task automatic test_sw_reset();
        push(1,  3'b000, 1'b0, 8'd0);
        push(9,  3'b000, 1'b0, 8'd0);
        push(10, 3'b001, 1'b0, 8'd0);
        push(13, 3'b001, 1'b0, 8'd0);
        push(14, 3'b011, 1'b0, 8'd0);
        push(18, 3'b111, 1'b0, 8'd0);
        push(21, 3'b111, 1'b0, 8'd0);
        push(22, 3'b111, 1'b1, 8'd0);
        sw_rst_req_i = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL sw_reset E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   sw_reset E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
            sw_rst_req_i = (e == 2);
        end
    endtask

    // Software reset to get back into RELEASE, then drop lock at rst_n_o=011.
    task automatic test_lock_loss();
        push(14, 3'b011, 1'b0, 8'd0);
        push(16, 3'b011, 1'b0, 8'd0);
        push(17, 3'b000, 1'b0, 8'd1);
        push(22, 3'b000, 1'b0, 8'd1);
        push(23, 3'b001, 1'b0, 8'd1);
        push(26, 3'b001, 1'b0, 8'd1);
        push(27, 3'b011, 1'b0, 8'd1);
        push(31, 3'b111, 1'b0, 8'd1);
        push(35, 3'b111, 1'b1, 8'd1);
        sw_rst_req_i = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL lock_loss E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   lock_loss E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
            if (e == 1)  sw_rst_req_i = 1'b0;
            if (e == 14) lock_i = 1'b0;
            if (e == 20) lock_i = 1'b1;
        end
    endtask

    // Lock loss reaches the FSM on edge 3 while sw_rst_req_i is high for that
    // cycle. Lock returns right away: a WAIT_LOCK entry re-releases on edge 6
    // with one extra loss; a wrong SW_RST entry would log a second loss.
    task automatic test_coincident();
        push(2, 3'b111, 1'b1, 8'd1);
        push(3, 3'b000, 1'b0, 8'd2);
        push(5, 3'b000, 1'b0, 8'd2);
        push(6, 3'b001, 1'b0, 8'd2);
        lock_i = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL coincident E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   coincident E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
            sw_rst_req_i = (e == 2);
            if (e == 3) lock_i = 1'b1;
        end
    endtask

    // 300 lock-loss periods of 3 high / 3 low cycles: one loss per period.
    // Count starts at 2, so it reads 254 after period 251 and 255 from 252 on.
    task automatic test_saturation();
        int exp_loss;
        exp_loss = 2;
        for (int p = 0; p < 300; p++) begin
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            if (p == 0 || p == 251 || p == 252 || p == 253 || p == 299)
                push(p, 3'b000, 1'b0, 8'(exp_loss));
            lock_i = 1'b1;
            repeat (3) @(posedge clk_i);
            #1;
            lock_i = 1'b0;
            repeat (3) @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == p) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL saturation period %0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             p, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   saturation period %0d: rst=%b rdy=%b loss=%0d", p, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
        end
    endtask

    // Reach rst_n_o=011, assert rst_n_i between edges, then restart from HOLD.
    task automatic test_async_reset();
        push(3, 3'b001, 1'b0, 8'd255);
        push(7, 3'b011, 1'b0, 8'd255);
        lock_i = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL async_pre E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   async_pre E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (rst_n_o !== 3'b000 || ready_o !== 1'b0 || lock_loss_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL async_assert: got rst=%b rdy=%b loss=%0d before next edge, want rst=000 rdy=0 loss=0",
                     rst_n_o, ready_o, lock_loss_cnt_o);
        end else begin
            $display("ok   async_assert: rst=%b rdy=%b loss=%0d", rst_n_o, ready_o, lock_loss_cnt_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        push(16, 3'b000, 1'b0, 8'd0);
        push(17, 3'b001, 1'b0, 8'd0);
        rst_n_i = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk_i);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at == e) begin
                ex = exp_q.pop_front();
                checks++;
                if (rst_n_o !== ex.rst || ready_o !== ex.rdy || lock_loss_cnt_o !== ex.loss) begin
                    errors++;
                    $display("FAIL async_restart E%0d: got rst=%b rdy=%b loss=%0d, want rst=%b rdy=%b loss=%0d",
                             e, rst_n_o, ready_o, lock_loss_cnt_o, ex.rst, ex.rdy, ex.loss);
                end else begin
                    $display("ok   async_restart E%0d: rst=%b rdy=%b loss=%0d", e, rst_n_o, ready_o, lock_loss_cnt_o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_late_lock();
        test_sw_reset();
        test_lock_loss();
        test_coincident();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates sequenced, per-domain active-low resets from the board reset, a PLL lock indication and a software reset request. Sits directly upstream of the synchronous-reset pulse stretchers: each `rst_n_o[k]` drives one stretcher's `rst_n_i`. Resets are asserted together and released one stage at a time, so downstream domains come out of reset in a fixed order.

## Interface
- `STAGES`, default 3: number of reset domains, ≥2.
- `HOLD_CYCLES`, default 16: minimum cycles all resets stay asserted after `rst_n_i` is released, ≥1.
- `GAP_CYCLES`, default 4: cycles between successive stage releases, ≥1.
- `SW_RST_CYCLES`, default 8: length of a software-requested reset, ≥1.

- `clk_i` input 1: single clock.
- `rst_n_i` input 1: asynchronous, active-low reset. Deassertion is synchronous to `clk_i`.
- `lock_i` input 1: PLL lock, asynchronous. Internally double-flop synchronized to `lock_s`, giving 2-cycle latency.
- `sw_rst_req_i` input 1: synchronous single-cycle software reset request.
- `rst_n_o` output STAGES: per-domain active-low resets. Bit 0 is released first.
- `ready_o` output 1: high once all stages are released and the system is in RUN.
- `lock_loss_cnt_o` output 8: saturating count of lock losses seen in RELEASE/RUN/SW_RST.

## Operation
- **Reset state** (asynchronous, while `rst_n_i`=0): FSM=HOLD, counters=0, `rst_n_o`=0, `ready_o`=0, `lock_loss_cnt_o`=0, synchronizer flops=0.
- **HOLD:** `cnt` increments each cycle. At `cnt`=HOLD_CYCLES-1, go to WAIT_LOCK and clear `cnt`. All outputs stay asserted. `lock_i` and `sw_rst_req_i` are ignored.
- **WAIT_LOCK:** when `lock_s`=1, go to RELEASE. On that same edge, set `rst_n_o[0]`=1 and clear `cnt`. `sw_rst_req_i` is ignored.
- **RELEASE:** `cnt` increments each cycle.
  - Stage k (k≥1) is set to 1 on the edge where `cnt` reaches k·GAP_CYCLES-1.
  - On the edge where `cnt` reaches STAGES·GAP_CYCLES-1, go to RUN and set `ready_o`=1.
- **RUN:** all `rst_n_o`=1 and `ready_o`=1. The FSM stays here until an exit event.
- **SW_RST:** entered from RELEASE or RUN when `sw_rst_req_i`=1.
  - On the entry edge, all `rst_n_o`=0, `ready_o`=0, and `cnt` is cleared.
  - At `cnt`=SW_RST_CYCLES-1, go to WAIT_LOCK.
  - Further requests while in SW_RST are ignored; they do not restart the count.
- **Lock loss:** `lock_s`=0 in RELEASE, RUN or SW_RST.
  - On the next edge: go to WAIT_LOCK, all `rst_n_o`=0, `ready_o`=0, `cnt` cleared.
  - `lock_loss_cnt_o` increments and saturates at 255.
- **Priority when events coincide in one cycle:** lock loss > software request > normal counting. A simultaneous lock loss and `sw_rst_req_i` give exactly one lock-loss transition.
- **Output invariants:**
  - Resets are only ever released in ascending order. Once set, `rst_n_o[k]` implies `rst_n_o[j]`=1 for all j<k.
  - All bits are asserted together, on a single edge.
  - `ready_o`=1 only in RUN.
- **Counter width:** `cnt` is sized by `$clog2` of the largest of HOLD_CYCLES, STAGES·GAP_CYCLES and SW_RST_CYCLES. It never wraps; each state exits exactly at its terminal value.
- **Registered outputs:** all outputs are registered; none are combinational from the inputs.

## Timing
E1 is the first rising edge with `rst_n_i`=1.
- **Cold start, `lock_i` steady high:**
  - HOLD exits on E_HOLD_CYCLES.
  - RELEASE is entered on E(HOLD_CYCLES+1), setting `rst_n_o[0]`.
  - Stage k is released k·GAP_CYCLES edges later.
  - `ready_o` rises STAGES·GAP_CYCLES edges after RELEASE entry.
- **`lock_i` rising:** there are 2 sync edges, then 1 edge to enter RELEASE.
- **`lock_i` falling:** there are 2 sync edges, then 1 edge to assert all resets (3 edges total from the input).
- **Software reset:** the request edge asserts all resets. WAIT_LOCK is entered SW_RST_CYCLES edges later, and RELEASE 1 edge after that if locked.
- **`rst_n_i` assertion mid-operation:** outputs clear immediately, with no clock required.

## Test plan
- **Cold start** (defaults, `lock_i`=1, release `rst_n_i`): `rst_n_o`=000 through E16, 001 at E17, 011 at E21, 111 at E25; `ready_o`=1 at E29.
- **Late lock:** hold `lock_i`=0 until after E40, then raise it. `rst_n_o`=000 until 3 edges after the rise, then the release sequence runs as in the cold-start case.
- **Software reset in RUN:** pulse `sw_rst_req_i`. `rst_n_o`=000 and `ready_o`=0 at the next edge; 001 at 9 edges after the request; full sequence repeats; `lock_loss_cnt_o` unchanged.
- **Lock loss during RELEASE at `rst_n_o`=011:** drop `lock_i`. Resets go to 000 3 edges later; `lock_loss_cnt_o`=1. Raising `lock_i` again restarts the release from 001.
- **Coincident events:** lock loss and `sw_rst_req_i` in the same cycle give WAIT_LOCK (not SW_RST) with a count of 1. Toggling lock loss 300 times saturates `lock_loss_cnt_o` at 255.
- **Async reset mid-sequence:** pull `rst_n_i` low between clock edges at `rst_n_o`=011. All outputs read 0 before the next edge, and the FSM restarts in HOLD.
